// File: rtl/pc_alu_datamem.sv
// rtl/pc_alu_datamem.sv - program counter, combinational ALU and word-addressed data memory
module pc_alu_datamem #(
    parameter int DMEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pcnext,
    input  logic        finish_flag,
    output logic [31:0] pc_reg,
    input  logic [3:0]  ALUctl,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] ALUout,
    output logic        zero,
    input  logic        write_enable,
    input  logic        read_enable,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data
);
    localparam int IDXW = $clog2(DMEM_DEPTH);

    logic [31:0]     r_pc;
    logic [31:0]     r_mem [DMEM_DEPTH] = '{default: '0};
    logic [IDXW-1:0] w_index;
    logic [31:0]     w_alu;
    logic            w_unused_addr;

    // finish_flag freezes the PC even when pcnext is asserted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= 32'h0;
        end else if (pcnext && !finish_flag) begin
            r_pc <= r_pc + 32'd4;
        end
    end

    assign pc_reg = r_pc;

    always_comb begin
        w_alu = 32'h0;
        case (ALUctl)
            4'd0:    w_alu = A & B;
            4'd1:    w_alu = A | B;
            4'd2:    w_alu = A + B;
            4'd6:    w_alu = A - B;
            4'd7:    w_alu = {31'h0, $signed(A) < $signed(B)};
            4'd12:   w_alu = ~(A | B);
            default: w_alu = 32'h0;
        endcase
    end

    assign ALUout = w_alu;
    assign zero   = (w_alu == 32'h0);

    // byte-lane and upper address bits are dropped, so addresses wrap over the memory
    assign w_index       = address[IDXW+1:2];
    assign w_unused_addr = ^{address[31:IDXW+2], address[1:0]};

    // memory is deliberately outside the reset domain
    always_ff @(posedge clk) begin
        if (write_enable) begin
            r_mem[w_index] <= write_data;
        end
    end

    assign read_data = read_enable ? r_mem[w_index] : 32'h0;
endmodule

// File: tb/tb_pc_alu_datamem.sv
// tb/tb_pc_alu_datamem.sv - directed table-driven bench for pc_alu_datamem
module tb_pc_alu_datamem;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        pcnext;
    logic        finish_flag;
    logic [31:0] pc_reg;
    logic [3:0]  ALUctl;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] ALUout;
    logic        zero;
    logic        write_enable;
    logic        read_enable;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_out;
        logic        exp_zero;
    } alu_vec_t;

    alu_vec_t vecs [14];

    pc_alu_datamem #(.DMEM_DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .pcnext(pcnext),
        .finish_flag(finish_flag),
        .pc_reg(pc_reg),
        .ALUctl(ALUctl),
        .A(A),
        .B(B),
        .ALUout(ALUout),
        .zero(zero),
        .write_enable(write_enable),
        .read_enable(read_enable),
        .address(address),
        .write_data(write_data),
        .read_data(read_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0]  = '{4'd2,  32'd5,          32'd3,          32'd8,          1'b0};
        vecs[1]  = '{4'd6,  32'd5,          32'd3,          32'd2,          1'b0};
        vecs[2]  = '{4'd0,  32'd5,          32'd3,          32'd1,          1'b0};
        vecs[3]  = '{4'd1,  32'd5,          32'd3,          32'd7,          1'b0};
        vecs[4]  = '{4'd6,  32'd9,          32'd9,          32'd0,          1'b1};
        vecs[5]  = '{4'd2,  32'hFFFFFFFF,   32'd1,          32'd0,          1'b1};
        vecs[6]  = '{4'd7,  32'hFFFFFFFF,   32'd1,          32'd1,          1'b0};
        vecs[7]  = '{4'd12, 32'd0,          32'd0,          32'hFFFFFFFF,   1'b0};
        vecs[8]  = '{4'd7,  32'd1,          32'hFFFFFFFF,   32'd0,          1'b1};
        vecs[9]  = '{4'd6,  32'd0,          32'd1,          32'hFFFFFFFF,   1'b0};
        vecs[10] = '{4'd3,  32'd5,          32'd3,          32'd0,          1'b1};
        vecs[11] = '{4'd15, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd0,          1'b1};
        vecs[12] = '{4'd12, 32'hF0F0F0F0,   32'h0F0F0000,   32'h00000F0F,   1'b0};
        vecs[13] = '{4'd7,  32'd3,          32'd5,          32'd1,          1'b0};

        reset = 1'b1; pcnext = 1'b0; finish_flag = 1'b0;
        ALUctl = 4'd0; A = '0; B = '0;
        write_enable = 1'b0; read_enable = 1'b0; address = '0; write_data = '0;

        // PC sequence: reset, three increments, then freeze
        @(negedge clk);
        check("pc_reset", pc_reg, 32'h0);
        reset = 1'b0; pcnext = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check($sformatf("pc_step%0d", i), pc_reg, 32'(4 * i));
        end
        finish_flag = 1'b1;
        @(negedge clk); @(negedge clk);
        check("pc_finish_hold", pc_reg, 32'd12);
        finish_flag = 1'b0; pcnext = 1'b0;
        @(negedge clk);
        check("pc_nonext_hold", pc_reg, 32'd12);

        // asynchronous reset mid-cycle, then pcnext ignored while held
        #2 reset = 1'b1;
        #1 check("pc_async_reset", pc_reg, 32'h0);
        pcnext = 1'b1;
        @(negedge clk); @(negedge clk);
        check("pc_reset_held", pc_reg, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("pc_first_after_reset", pc_reg, 32'd4);
        pcnext = 1'b0;

        for (int i = 0; i < 14; i++) begin
            ALUctl = vecs[i].ctl; A = vecs[i].a; B = vecs[i].b;
            #1;
            check($sformatf("alu_out[%0d]", i), ALUout, vecs[i].exp_out);
            check($sformatf("alu_zero[%0d]", i), {31'h0, zero}, {31'h0, vecs[i].exp_zero});
        end

        // ALU is untouched by reset
        ALUctl = 4'd2; A = 32'd5; B = 32'd3;
        reset = 1'b1;
        #1 check("alu_during_reset", ALUout, 32'd8);
        reset = 1'b0;

        @(negedge clk);
        address = 32'd8; read_enable = 1'b1;
        #1 check("mem_init_zero", read_data, 32'h0);
        write_enable = 1'b1; write_data = 32'hDEADBEEF;
        @(negedge clk);
        write_enable = 1'b0;
        check("mem_read_8", read_data, 32'hDEADBEEF);
        address = 32'd9;
        #1 check("mem_read_9", read_data, 32'hDEADBEEF);
        address = 32'd8 + DEPTH * 4;
        #1 check("mem_read_wrap", read_data, 32'hDEADBEEF);
        read_enable = 1'b0;
        #1 check("mem_read_disabled", read_data, 32'h0);

        // same-index read and write on one edge
        @(negedge clk);
        address = 32'd4; read_enable = 1'b1; write_enable = 1'b1; write_data = 32'h55;
        #1 check("mem_rw_before", read_data, 32'h0);
        @(negedge clk);
        write_enable = 1'b0;
        check("mem_rw_after", read_data, 32'h55);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mem_survives_reset", read_data, 32'h55);

        // write edge coinciding with reset assertion
        address = 32'd12; write_enable = 1'b1; write_data = 32'hA5A5A5A5;
        #4 reset = 1'b1;
        @(negedge clk);
        write_enable = 1'b0; reset = 1'b0;
        check("mem_write_in_reset", read_data, 32'hA5A5A5A5);
        check("pc_after_write_reset", pc_reg, 32'h0);

        // write and read to different indices on one edge
        address = 32'd16; write_enable = 1'b1; write_data = 32'h12345678;
        #1 check("mem_w16_before", read_data, 32'h0);
        @(negedge clk);
        write_enable = 1'b0;
        check("mem_w16_after", read_data, 32'h12345678);
        address = 32'd8;
        #1 check("mem_8_intact", read_data, 32'hDEADBEEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
